// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder.
//   dm_size_e  : access size encodings as carried on req_size
//   dm_state_e : responder FSM states
//   dm_extend  : sign/zero extension of a right-justified load value
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } dm_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } dm_state_e;

  // raw holds the loaded bytes right-justified; only the low 8/16 bits
  // are significant for byte/halfword loads.
  function automatic logic [31:0] dm_extend(input logic [31:0] raw,
                                            input logic [1:0]  size,
                                            input logic        se);
    logic [31:0] res;
    res = raw;
    case (size)
      SZ_BYTE: res = se ? {{24{raw[7]}}, raw[7:0]}   : {24'h0, raw[7:0]};
      SZ_HALF: res = se ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dm_align_check.sv
// Combinational alignment / size legality check.
//   size    : access size (dm_size_e encoding)
//   addr_lo : low two bits of the byte address
//   err     : 1 for a misaligned halfword/word or the reserved size
module dm_align_check
  import dm_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       err
);

  always_comb begin
    err = 1'b0;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr_lo[0];
      SZ_WORD: err = |addr_lo;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Big-endian byte-addressed data memory answering MEM-stage load/store
// requests with a fixed multi-cycle latency and a stall to the hazard unit.
//   Clk, R       : clock, asynchronous active-high reset
//   req_*        : access request (valid, rw 1=store, addr, wdata, size, se)
//   resp_valid   : one-cycle completion pulse
//   resp_rdata   : load result (0 for stores/errors), held until next response
//   resp_err     : misaligned or reserved-size access, held like resp_rdata
//   stall        : hold the pipeline while an access is accepted or in flight
//   pre_we/addr/wdata : byte preload port, honoured only when idle with no request
module data_memory_responder
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned LATENCY = 2
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              req_valid,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              stall,
  input  logic              pre_we,
  input  logic [ADDR_W-1:0] pre_addr,
  input  logic [7:0]        pre_wdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] mem [DEPTH];

  dm_state_e state, state_n;
  logic [3:0] cnt;

  // Latched request; req_* are not looked at again after acceptance.
  logic              l_rw;
  logic [ADDR_W-1:0] l_addr;
  logic [31:0]       l_wdata;
  logic [1:0]        l_size;
  logic              l_se;
  logic              l_err;

  logic [ADDR_W-1:0] a0, a1, a2, a3;
  logic [31:0]       raw;
  logic              fire;
  logic              store_en;
  logic              pre_ok;

  dm_align_check u_align (
    .size    (l_size),
    .addr_lo (l_addr[1:0]),
    .err     (l_err)
  );

  // Byte lanes wrap modulo the memory depth through natural overflow.
  assign a0 = l_addr;
  assign a1 = l_addr + ADDR_W'(1);
  assign a2 = l_addr + ADDR_W'(2);
  assign a3 = l_addr + ADDR_W'(3);

  assign fire     = (state == ST_BUSY) && (cnt == '0);
  assign store_en = fire && l_rw && !l_err;
  assign pre_ok   = pre_we && (state == ST_IDLE) && !req_valid;
  assign stall    = ((state == ST_IDLE) && req_valid) || (state == ST_BUSY);

  always_comb begin
    raw = '0;
    case (l_size)
      SZ_BYTE: raw = {24'h0, mem[a0]};
      SZ_HALF: raw = {16'h0, mem[a0], mem[a1]};
      default: raw = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (req_valid) state_n = ST_BUSY;
      ST_BUSY: if (cnt == '0) state_n = ST_RESP;
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge R) begin
    if (R) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      l_rw       <= 1'b0;
      l_addr     <= '0;
      l_wdata    <= '0;
      l_size     <= '0;
      l_se       <= 1'b0;
    end else begin
      state      <= state_n;
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            l_rw    <= req_rw;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
            l_size  <= req_size;
            l_se    <= req_se;
            cnt     <= 4'(LATENCY - 1);
          end
        end
        ST_BUSY: begin
          if (cnt == '0) begin
            // Response fields are registered here so they line up with
            // resp_valid in the RESP cycle and persist afterwards.
            resp_valid <= 1'b1;
            resp_err   <= l_err;
            resp_rdata <= (l_err || l_rw) ? '0 : dm_extend(raw, l_size, l_se);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory has no reset; an abandoned store never writes because R
  // forces the FSM out of BUSY before the write edge.
  always_ff @(posedge Clk) begin
    if (store_en) begin
      case (l_size)
        SZ_BYTE: mem[a0] <= l_wdata[7:0];
        SZ_HALF: begin
          mem[a0] <= l_wdata[15:8];
          mem[a1] <= l_wdata[7:0];
        end
        SZ_WORD: begin
          mem[a0] <= l_wdata[31:24];
          mem[a1] <= l_wdata[23:16];
          mem[a2] <= l_wdata[15:8];
          mem[a3] <= l_wdata[7:0];
        end
        default: ;
      endcase
    end else if (pre_ok) begin
      mem[pre_addr] <= pre_wdata;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned LATENCY = 2;

  logic              Clk = 1'b0;
  logic              R = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_rw = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [1:0]        req_size = '0;
  logic              req_se = 1'b0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              stall;
  logic              pre_we = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [7:0]        pre_wdata = '0;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  data_memory_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .Clk(Clk), .R(R),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_se(req_se),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall),
    .pre_we(pre_we), .pre_addr(pre_addr), .pre_wdata(pre_wdata)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc = cyc + 1;

  typedef struct {
    logic        rw;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        se;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [8:0] a, input logic [7:0] d);
    @(negedge Clk);
    req_valid = 1'b0;
    pre_we    = 1'b1;
    pre_addr  = a;
    pre_wdata = d;
  endtask

  task automatic idle();
    @(negedge Clk);
    req_valid = 1'b0;
    pre_we    = 1'b0;
  endtask

  // Presents one request and holds it (as a stalled pipeline would) until
  // the response cycle; the caller drives the next thing at the next negedge.
  task automatic access(input string name, input logic rw, input logic [8:0] a,
                        input logic [31:0] wd, input logic [1:0] sz, input logic se,
                        input logic [31:0] exp_rd, input logic exp_err,
                        output int resp_cyc);
    int lat;
    bit got;
    @(negedge Clk);
    pre_we    = 1'b0;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = a;
    req_wdata = wd;
    req_size  = sz;
    req_se    = se;
    #1;
    chk({name, ".stall0"}, 32'(stall), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge Clk);
      lat++;
      if (resp_valid) got = 1'b1;
      else if (stall !== 1'b1) chk({name, ".stall_busy"}, 32'(stall), 32'd1);
    end
    chk({name, ".got_resp"}, 32'(got), 32'd1);
    chk({name, ".latency"}, lat, LATENCY + 1);
    chk({name, ".stall_resp"}, 32'(stall), 32'd0);
    chk({name, ".rdata"}, resp_rdata, exp_rd);
    chk({name, ".err"}, 32'(resp_err), 32'(exp_err));
    resp_cyc = cyc;
  endtask

  initial begin
    int c0, c1;
    // rw addr wdata size se exp_rdata exp_err
    tbl[0]  = '{1'b0, 9'd0,  32'h0,        2'b10, 1'b0, 32'h12345678, 1'b0};
    tbl[1]  = '{1'b1, 9'd2,  32'h000000F0, 2'b00, 1'b0, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 9'd2,  32'h0,        2'b00, 1'b1, 32'hFFFFFFF0, 1'b0};
    tbl[3]  = '{1'b0, 9'd2,  32'h0,        2'b00, 1'b0, 32'h000000F0, 1'b0};
    tbl[4]  = '{1'b1, 9'd0,  32'h00008001, 2'b01, 1'b0, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 9'd0,  32'h0,        2'b01, 1'b1, 32'hFFFF8001, 1'b0};
    tbl[6]  = '{1'b0, 9'd0,  32'h0,        2'b10, 1'b0, 32'h8001F078, 1'b0};
    tbl[7]  = '{1'b1, 9'd8,  32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 9'd9,  32'h0,        2'b00, 1'b0, 32'h000000AD, 1'b0};
    tbl[9]  = '{1'b0, 9'd10, 32'h0,        2'b01, 1'b0, 32'h0000BEEF, 1'b0};
    tbl[10] = '{1'b1, 9'd6,  32'h55555555, 2'b10, 1'b0, 32'h0,        1'b1};
    tbl[11] = '{1'b0, 9'd3,  32'h0,        2'b01, 1'b0, 32'h0,        1'b1};
    tbl[12] = '{1'b0, 9'd0,  32'h0,        2'b11, 1'b0, 32'h0,        1'b1};
    tbl[13] = '{1'b0, 9'd6,  32'h0,        2'b01, 1'b0, 32'h00001122, 1'b0};
    tbl[14] = '{1'b0, 9'd8,  32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[15] = '{1'b0, 9'd10, 32'h0,        2'b01, 1'b1, 32'hFFFFBEEF, 1'b0};
    tbl[16] = '{1'b0, 9'd11, 32'h0,        2'b00, 1'b1, 32'hFFFFFFEF, 1'b0};

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    R = 1'b0;

    preload(9'd0, 8'h12);
    preload(9'd1, 8'h34);
    preload(9'd2, 8'h56);
    preload(9'd3, 8'h78);
    preload(9'd6, 8'h11);
    preload(9'd7, 8'h22);
    preload(9'd16, 8'h01);
    preload(9'd17, 8'h02);
    preload(9'd18, 8'h03);
    preload(9'd19, 8'h04);
    preload(9'd20, 8'hAA);
    preload(9'd21, 8'hBB);
    preload(9'd22, 8'hCC);
    preload(9'd23, 8'hDD);

    // Vectors are issued back to back, so the sticky resp_err of one
    // is cleared by the next.
    for (int i = 0; i < 17; i++)
      access($sformatf("vec%0d", i), tbl[i].rw, tbl[i].addr, tbl[i].wdata,
             tbl[i].size, tbl[i].se, tbl[i].exp_rdata, tbl[i].exp_err, c0);

    // Back-to-back spacing
    access("b2b_a", 1'b0, 9'd8, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, c0);
    access("b2b_b", 1'b0, 9'd0, 32'h0, 2'b10, 1'b0, 32'h8001F078, 1'b0, c1);
    chk("b2b.spacing", c1 - c0, LATENCY + 2);

    // Reset mid-store, preload accepted while R is high
    access("pre_rst_ld", 1'b0, 9'd16, 32'h0, 2'b10, 1'b0, 32'h01020304, 1'b0, c0);
    @(negedge Clk);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 9'd16;
    req_wdata = 32'hA5A5A5A5; req_size = 2'b10; req_se = 1'b0;
    @(negedge Clk);
    chk("rst_mid.stall_busy", 32'(stall), 32'd1);
    req_valid = 1'b0;
    R = 1'b1;
    pre_we = 1'b1; pre_addr = 9'd24; pre_wdata = 8'h5A;
    #1;
    chk("rst_mid.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid.resp_rdata", resp_rdata, 32'd0);
    chk("rst_mid.resp_err", 32'(resp_err), 32'd0);
    chk("rst_mid.stall", 32'(stall), 32'd0);
    #7;
    R = 1'b0;
    @(negedge Clk);
    pre_we = 1'b0;
    chk("rst_mid.idle", 32'(stall), 32'd0);
    chk("rst_mid.no_resp", 32'(resp_valid), 32'd0);
    access("post_rst_ld", 1'b0, 9'd16, 32'h0, 2'b10, 1'b0, 32'h01020304, 1'b0, c0);
    access("rst_preload", 1'b0, 9'd24, 32'h0, 2'b00, 1'b0, 32'h0000005A, 1'b0, c0);

    // Preload during BUSY is dropped; req_* changes during BUSY are ignored
    @(negedge Clk);
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 9'd20;
    req_size = 2'b10; req_se = 1'b0;
    @(negedge Clk);
    chk("blk.stall", 32'(stall), 32'd1);
    pre_we = 1'b1; pre_addr = 9'd20; pre_wdata = 8'h77;
    req_addr = 9'd8; req_size = 2'b00; req_rw = 1'b1;
    @(negedge Clk);
    pre_we = 1'b0;
    @(negedge Clk);
    chk("blk.resp_valid", 32'(resp_valid), 32'd1);
    chk("blk.rdata", resp_rdata, 32'hAABBCCDD);
    access("blk_check", 1'b0, 9'd20, 32'h0, 2'b00, 1'b0, 32'h000000AA, 1'b0, c0);
    access("blk_mem8", 1'b0, 9'd8, 32'h0, 2'b00, 1'b0, 32'h000000DE, 1'b0, c0);

    idle();
    @(negedge Clk);
    chk("end.resp_valid", 32'(resp_valid), 32'd0);
    chk("end.rdata_held", resp_rdata, 32'h000000DE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
